prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 118 +++++++++++
 tb/tb_prod_accum.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - block multiply-accumulate with saturating signed accumulator and result handshake
module prod_accum #(
  parameter int ACC_W = 20,
  parameter int LEN_W = 5
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      p_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             sat_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [ACC_W:0]   p_ext;
  logic [ACC_W:0]   sum_w;
  logic             ovf;
  logic             xfer;

  // One guard bit: the two top bits disagree exactly when the true sum left the ACC_W range.
  always_comb begin
    p_ext = {{(ACC_W+1-16){p_in[15]}}, p_in};
    sum_w = {acc_q[ACC_W-1], acc_q} + p_ext;
    ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    acc_d = sum_w[ACC_W-1:0];
    if (ovf) begin
      acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    cnt_d = cnt_q - LEN_W'(1);
    xfer  = in_valid && in_ready_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q  <= len;
            acc_q  <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ACC;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
            sat_q <= sat_q | ovf;
            cnt_q <= cnt_d;
            if (cnt_q == LEN_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - scoreboard bench for prod_accum
module tb_prod_accum;
  localparam int ACC_W = 20;
  localparam int LEN_W = 5;
  localparam int MAXV  = (1 << (ACC_W-1)) - 1;
  localparam int MINV  = -(1 << (ACC_W-1));

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0]      p_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             sat;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  prod_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .rst(rst), .start(start), .len(len), .p_in(p_in),
    .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { int acc; bit sat; } exp_t;
  exp_t sb[$];
  int   prods[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int acc_s();
    return int'($signed(acc_out));
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_acc"}, acc_s(), 0);
    check({tag, "_sat"}, int'(sat), 0);
    check({tag, "_ov"}, int'(out_valid), 0);
    check({tag, "_ir"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Runs one block from IDLE using the products in prods[]; hold = cycles out_ready stays low.
  task automatic run_block(input int gaps, input int hold, input bit start_mid);
    int   L;
    int   m_acc;
    bit   m_sat;
    exp_t e;
    int   w;
    L = prods.size();
    m_acc = 0;
    m_sat = 0;
    foreach (prods[i]) begin
      m_acc = m_acc + prods[i];
      if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1; end
      if (m_acc < MINV) begin m_acc = MINV; m_sat = 1; end
    end
    sb.push_back('{acc: m_acc, sat: m_sat});

    start = 1'b1;
    len = LEN_W'(L);
    tick();
    start = 1'b0;
    len = ~LEN_W'(L);
    check("busy_after_start", int'(busy), 1);
    if (L == 0) check("len0_in_ready", int'(in_ready), 0);

    m_acc = 0;
    m_sat = 0;
    foreach (prods[i]) begin
      if (i > 0) begin
        repeat (gaps) begin
          in_valid = 1'b0;
          start = start_mid;
          tick();
          check("gap_acc_hold", acc_s(), m_acc);
          check("gap_ready", int'(in_ready), 1);
        end
      end
      in_valid = 1'b1;
      p_in = 16'(prods[i]);
      start = start_mid;
      w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      if (w == 20) check("in_ready_timeout", 0, 1);
      tick();
      m_acc = m_acc + prods[i];
      if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1; end
      if (m_acc < MINV) begin m_acc = MINV; m_sat = 1; end
      check($sformatf("xfer%0d_acc", i+1), acc_s(), m_acc);
      check($sformatf("xfer%0d_sat", i+1), int'(sat), int'(m_sat));
    end
    in_valid = 1'b0;
    start = 1'b0;

    check("out_valid_latency", int'(out_valid), 1);
    check("done_in_ready", int'(in_ready), 0);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("result_acc", acc_s(), e.acc);
      check("result_sat", int'(sat), int'(e.sat));
    end
    repeat (hold) begin
      out_ready = 1'b0;
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_acc", acc_s(), e.acc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_valid", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_acc_kept", acc_s(), e.acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    prods = '{6, -2, 35};
    run_block(0, 0, 0);

    prods.delete();
    for (int i = 0; i < 31; i++) prods.push_back(32767);
    run_block(0, 1, 0);

    prods.delete();
    for (int i = 0; i < 20; i++) prods.push_back(-32768);
    run_block(0, 0, 0);

    prods = '{-1, -1};
    run_block(2, 5, 0);

    prods.delete();
    run_block(0, 2, 0);

    // Reset mid-ACC after one transfer, with start held high alongside.
    start = 1'b1;
    len = 5'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    p_in = 16'd100;
    tick();
    in_valid = 1'b0;
    check("pre_rst_acc", acc_s(), 100);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_idle_zero("rst_mid_acc");

    prods = '{1000, -3000, 250, 7};
    run_block(1, 0, 1);

    // Reset mid-DONE wins over out_ready.
    start = 1'b1;
    len = 5'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    p_in = 16'd9;
    tick();
    in_valid = 1'b0;
    check("pre_rst_done_valid", int'(out_valid), 1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check_idle_zero("rst_mid_done");

    for (int b = 0; b < 3; b++) begin
      int n;
      n = int'($urandom_range(1, 8));
      prods.delete();
      for (int i = 0; i < n; i++) prods.push_back(int'($urandom_range(0, 32767)) - 16384);
      run_block(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
    end

    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
